// File: rtl/num_ascii_serializer.sv
// Prints signed 32-bit numbers as decimal ASCII over a byte handshake stream.
// Digits come from repeated subtraction of powers of ten, so no divider is needed.
module num_ascii_serializer #(
    parameter logic [7:0] SEPARATOR  = 8'h20,
    parameter logic [7:0] TERMINATOR = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        num_valid,
    input  logic [31:0] num_data,
    input  logic        num_last,
    output logic        num_ready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic [10:0] num_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        CALC,
        EMIT,
        SEP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [3:0]  digit_q, digit_d;
    logic [3:0]  idx_q, idx_d;
    logic        neg_q, neg_d;
    logic        last_q, last_d;
    logic        started_q, started_d;
    logic [10:0] count_q, count_d;

    logic [31:0] pow;
    logic        magGe;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    assign pow   = pow10(idx_q);
    assign magGe = (mag_q >= pow);

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        digit_d    = digit_q;
        idx_d      = idx_q;
        neg_d      = neg_q;
        last_d     = last_q;
        started_d  = started_q;
        count_d    = count_q;
        num_ready  = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;

        case (state_q)
            IDLE: begin
                num_ready = 1'b1;
                if (num_valid) begin
                    // Two's-complement negate; 0x80000000 maps to itself, i.e. 2147483648 unsigned.
                    neg_d     = num_data[31];
                    mag_d     = num_data[31] ? (~num_data + 32'd1) : num_data;
                    last_d    = num_last;
                    idx_d     = 4'd9;
                    digit_d   = 4'd0;
                    started_d = 1'b0;
                    state_d   = num_data[31] ? SIGN : CALC;
                end
            end

            SIGN: begin
                char_valid = 1'b1;
                char_data  = 8'h2D;
                // SIGN is only entered with neg set; a cleared flag means there is no sign to send.
                if (char_ready || !neg_q) begin
                    state_d = CALC;
                end
            end

            CALC: begin
                if (magGe) begin
                    mag_d   = mag_q - pow;
                    digit_d = digit_q + 4'd1;
                end else if ((digit_q != 4'd0) || started_q || (idx_q == 4'd0)) begin
                    state_d = EMIT;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end

            EMIT: begin
                char_valid = 1'b1;
                char_data  = 8'h30 + {4'h0, digit_q};
                if (char_ready) begin
                    started_d = 1'b1;
                    digit_d   = 4'd0;
                    if (idx_q == 4'd0) begin
                        state_d = SEP;
                    end else begin
                        idx_d   = idx_q - 4'd1;
                        state_d = CALC;
                    end
                end
            end

            SEP: begin
                char_valid = 1'b1;
                char_data  = last_q ? TERMINATOR : SEPARATOR;
                if (char_ready) begin
                    count_d = (count_q == 11'h7FF) ? count_q : (count_q + 11'd1);
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst || clear) begin
            num_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q   <= IDLE;
            mag_q     <= 32'd0;
            digit_q   <= 4'd0;
            idx_q     <= 4'd0;
            neg_q     <= 1'b0;
            last_q    <= 1'b0;
            started_q <= 1'b0;
            count_q   <= 11'd0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            digit_q   <= digit_d;
            idx_q     <= idx_d;
            neg_q     <= neg_d;
            last_q    <= last_d;
            started_q <= started_d;
            count_q   <= count_d;
        end
    end

    assign num_count = count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_num_ascii_serializer.sv
// Directed bench for num_ascii_serializer: table of numbers with expected byte strings,
// plus hand-written back-to-back, reset and clear sequences.
module tb_num_ascii_serializer;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        num_valid;
    logic [31:0] num_data;
    logic        num_last;
    logic        num_ready;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [10:0] num_count;
    logic        busy;

    num_ascii_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .num_valid  (num_valid),
        .num_data   (num_data),
        .num_last   (num_last),
        .num_ready  (num_ready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .num_count  (num_count),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] num;
        logic        last;
        logic        toggle;
        string       expStr;
    } vec_t;

    vec_t        vecs [7];
    logic [7:0]  rxQ [$];
    int          assertCount = 0;
    int          failCount   = 0;
    int          expCount    = 0;
    logic        toggleMode  = 1'b0;
    logic [3:0]  readyPat    = 4'b1001;
    int          phase       = 0;
    logic        prevStall   = 1'b0;
    logic [7:0]  prevData    = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input int act, input int expv);
        assertCount++;
        if (act !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Collect every handshaken byte and verify that stalled bytes hold steady.
    always @(negedge clk) begin
        if (prevStall && !rst && !clear) begin
            check("stall valid held", int'(char_valid), 1);
            check("stall data held", int'(char_data), int'(prevData));
        end
        if (char_valid && char_ready && !rst && !clear) begin
            rxQ.push_back(char_data);
        end
        prevStall = char_valid && !char_ready && !rst && !clear;
        prevData  = char_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggleMode) begin
            char_ready = readyPat[phase];
            phase      = (phase + 1) % 4;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] value, input logic lastFlag);
        logic accepted;
        accepted  = 1'b0;
        num_valid = 1'b1;
        num_data  = value;
        num_last  = lastFlag;
        for (int t = 0; t < 2000 && !accepted; t++) begin
            @(negedge clk);
            accepted = num_ready;
            tick();
        end
        num_valid = 1'b0;
        if (!accepted) check("accept timeout", 0, 1);
    endtask

    task automatic waitDone(input int n);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (rxQ.size() >= n && !busy) done = 1'b1;
            else tick();
        end
        if (!done) check("completion timeout", 0, 1);
    endtask

    task automatic waitValid();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (char_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) check("valid timeout", 0, 1);
    endtask

    task automatic takeByte(input string name, input logic [7:0] expByte);
        waitValid();
        check(name, int'(char_data), int'(expByte));
        @(posedge clk);
        #1;
        char_ready = 1'b1;
        @(posedge clk);
        #1;
        char_ready = 1'b0;
    endtask

    task automatic checkOutput(input string name, input string expStr);
        check({name, " length"}, rxQ.size(), expStr.len());
        for (int k = 0; k < expStr.len() && k < rxQ.size(); k++) begin
            check($sformatf("%s byte %0d", name, k), int'(rxQ[k]), int'(expStr[k]));
        end
        check({name, " num_count"}, int'(num_count), expCount);
        check({name, " busy"}, int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{num: 32'd0,          last: 1'b1, toggle: 1'b0, expStr: "0\n"};
        vecs[1] = '{num: 32'h8000_0000,  last: 1'b1, toggle: 1'b0, expStr: "-2147483648\n"};
        vecs[2] = '{num: 32'd1000000000, last: 1'b0, toggle: 1'b0, expStr: "1000000000 "};
        vecs[3] = '{num: 32'd123,        last: 1'b1, toggle: 1'b1, expStr: "123\n"};
        vecs[4] = '{num: 32'h7FFF_FFFF,  last: 1'b0, toggle: 1'b0, expStr: "2147483647 "};
        vecs[5] = '{num: 32'hFFFF_FFFF,  last: 1'b1, toggle: 1'b0, expStr: "-1\n"};
        vecs[6] = '{num: 32'd10,         last: 1'b0, toggle: 1'b0, expStr: "10 "};

        rst        = 1'b1;
        clear      = 1'b0;
        num_valid  = 1'b0;
        num_data   = 32'd0;
        num_last   = 1'b0;
        char_ready = 1'b1;

        // Reset state: num_ready must stay low while rst is held.
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset num_ready", int'(num_ready), 0);
        check("reset char_valid", int'(char_valid), 0);
        check("reset char_data", int'(char_data), 0);
        check("reset busy", int'(busy), 0);
        check("reset num_count", int'(num_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset num_ready", int'(num_ready), 1);

        for (int v = 0; v < 7; v++) begin
            tick();
            rxQ.delete();
            toggleMode = vecs[v].toggle;
            phase      = 1;
            char_ready = 1'b1;
            applyStimulus(vecs[v].num, vecs[v].last);
            waitDone(vecs[v].expStr.len());
            toggleMode = 1'b0;
            expCount++;
            checkOutput($sformatf("vec%0d", v), vecs[v].expStr);
        end

        // Back-to-back numbers with no idle gap byte.
        tick();
        rxQ.delete();
        char_ready = 1'b1;
        applyStimulus(32'd5, 1'b0);
        applyStimulus(32'hFFFF_FFF9, 1'b1);
        waitDone(5);
        expCount += 2;
        checkOutput("back2back", "5 -7\n");
        check("back2back num_ready", int'(num_ready), 1);

        // Reset while the inner "0" of -4096 is pending, alongside a ready pulse.
        tick();
        rxQ.delete();
        char_ready = 1'b0;
        applyStimulus(32'hFFFF_F000, 1'b0);
        takeByte("rst seq sign", 8'h2D);
        takeByte("rst seq digit4", 8'h34);
        waitValid();
        check("rst seq pending zero", int'(char_data), 32'h30);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        char_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst seq char_valid", int'(char_valid), 0);
        check("rst seq busy", int'(busy), 0);
        check("rst seq num_count", int'(num_count), 0);
        for (int t = 0; t < 5; t++) tick();
        check("rst seq byte total", rxQ.size(), 2);
        expCount = 0;
        rxQ.delete();
        applyStimulus(32'd9, 1'b1);
        waitDone(2);
        expCount++;
        checkOutput("after rst", "9\n");

        // Clear aborts a stalled number just like rst.
        tick();
        rxQ.delete();
        char_ready = 1'b0;
        applyStimulus(32'd77, 1'b1);
        waitValid();
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear      = 1'b0;
        char_ready = 1'b1;
        @(negedge clk);
        check("clear char_valid", int'(char_valid), 0);
        check("clear busy", int'(busy), 0);
        check("clear num_count", int'(num_count), 0);
        check("clear byte total", rxQ.size(), 0);
        expCount = 0;
        tick();
        applyStimulus(32'd6, 1'b1);
        waitDone(2);
        expCount++;
        checkOutput("after clear", "6\n");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
